// File: rtl/nx1_stream_mux.sv
// N-input registered stream multiplexer with manual-select or round-robin grant.
// One output register stage; the source index travels with each beat.
module nx1_stream_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N = 4,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_src,
  output logic [15:0]          beat_cnt
);

  localparam int unsigned IDXW = SELW + 1;

  logic            load_en;
  logic            grant_valid;
  logic [SELW-1:0] grant;
  logic [SELW-1:0] ptr;
  logic [IDXW-1:0] scan_idx;
  logic            xfer;

  assign load_en = !out_valid || out_ready;

  // Grant selection: sel in manual mode, first valid channel from ptr in round-robin.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    scan_idx    = '0;
    if (!mode) begin
      grant       = sel;
      grant_valid = (32'(sel) < N);
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        scan_idx = IDXW'(ptr) + IDXW'(i);
        if (scan_idx >= IDXW'(N)) scan_idx = scan_idx - IDXW'(N);
        if (!grant_valid && in_valid[scan_idx[SELW-1:0]]) begin
          grant_valid = 1'b1;
          grant       = scan_idx[SELW-1:0];
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && grant_valid) in_ready[grant] = 1'b1;
  end

  assign xfer = load_en && grant_valid && in_valid[grant];

  // Output register stage, beat counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_src   <= '0;
      beat_cnt  <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (xfer) begin
        out_data  <= in_data[32'(grant)*WIDTH +: WIDTH];
        out_src   <= grant;
        out_valid <= 1'b1;
        beat_cnt  <= beat_cnt + 16'd1;
        if (mode) ptr <= (32'(grant) == N - 1) ? '0 : grant + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nx1_stream_mux.sv
// Bench for nx1_stream_mux: directed scenarios plus randomized traffic against a
// behavioural model (N=4), and a second N=3 instance for non-power-of-two wrap.
module tb_nx1_stream_mux;
  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned N3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [W-1:0]   ch [N];
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic           mode, out_valid, out_ready;
  logic [1:0]     sel, out_src;
  logic [W-1:0]   out_data;
  logic [15:0]    beat_cnt;

  logic [W-1:0]    ch3 [N3];
  logic [N3*W-1:0] in_data3;
  logic [N3-1:0]   in_valid3, in_ready3;
  logic            mode3, out_valid3, out_ready3;
  logic [1:0]      sel3, out_src3;
  logic [W-1:0]    out_data3;
  logic [15:0]     beat_cnt3;

  always_comb begin
    in_data = '0;
    for (int k = 0; k < N; k++) in_data[k*W +: W] = ch[k];
  end
  always_comb begin
    in_data3 = '0;
    for (int k = 0; k < N3; k++) in_data3[k*W +: W] = ch3[k];
  end

  nx1_stream_mux #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_src(out_src), .beat_cnt(beat_cnt));

  nx1_stream_mux #(.WIDTH(W), .N(N3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_src(out_src3), .beat_cnt(beat_cnt3));

  int checks = 0;
  int errors = 0;

  // Behavioural model of the N=4 instance
  int          m_ptr, m_src;
  bit          m_ov;
  logic [W-1:0] m_od;
  int          m_cnt;

  function automatic void ref_grant(input bit md, input int s, input logic [N-1:0] v,
                                    input int p, output bit gv, output int g);
    gv = 0;
    g  = 0;
    if (!md) begin
      g  = s;
      gv = (s < N);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!gv && v[(p + i) % N]) begin
          gv = 1;
          g  = (p + i) % N;
        end
      end
    end
  endfunction

  function automatic logic [N-1:0] ref_ready();
    bit gv;
    int g;
    ref_grant(mode, int'(sel), in_valid, m_ptr, gv, g);
    if (rst_n && (!m_ov || out_ready) && gv) return N'(1) << g;
    return '0;
  endfunction

  // One clock cycle: model advances with the DUT; outputs sampled 1 time unit after the edge.
  task automatic step();
    bit gv, ld, x;
    int g;
    ref_grant(mode, int'(sel), in_valid, m_ptr, gv, g);
    ld = !m_ov || out_ready;
    x  = gv && in_valid[g];
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0; m_ov = 0; m_od = '0; m_src = 0; m_cnt = 0;
    end else if (ld) begin
      if (x) begin
        m_od = ch[g]; m_src = g; m_ov = 1; m_cnt = (m_cnt + 1) % 65536;
        if (mode) m_ptr = (g + 1) % N;
      end else begin
        m_ov = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode = 1'b1; sel = '0; in_valid = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < N; k++) ch[k] = $urandom;
    mode3 = 1'b0; sel3 = '0; in_valid3 = '0; out_ready3 = 1'b1;
    for (int k = 0; k < N3; k++) ch3[k] = $urandom;
    step();
    checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (beat_cnt !== 16'd0) begin errors++; $display("FAIL reset_beat_cnt: got %0d expected 0", beat_cnt); end
    checks++; if (out_data !== '0 || out_src !== 2'd0) begin errors++; $display("FAIL reset_out_data_src: got %h/%0d expected 0/0", out_data, out_src); end
    checks++; if (in_ready3 !== 3'b000) begin errors++; $display("FAIL reset_in_ready_n3: got %b expected 000", in_ready3); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL release_in_ready: got %b expected 0001", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== ch[0]) begin
      errors++; $display("FAIL first_load: got v=%b src=%0d data=%h expected v=1 src=0 data=%h", out_valid, out_src, out_data, ch[0]); end
    checks++; if (beat_cnt !== 16'd1) begin errors++; $display("FAIL first_load_cnt: got %0d expected 1", beat_cnt); end
  endtask

  task automatic test_manual();
    // Asynchronous reset with a beat held discards it at once
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || beat_cnt !== 16'd0) begin
      errors++; $display("FAIL async_reset: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, beat_cnt); end
    step();
    rst_n = 1'b1;
    mode = 1'b0; sel = 2'd2; ch[2] = 32'hDEADBEEF; in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL manual_in_ready: got %b expected 0100", in_ready); end
    step();
    checks++; if (out_data !== 32'hDEADBEEF || out_src !== 2'd2 || beat_cnt !== 16'd1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL manual_load: got data=%h src=%0d cnt=%0d v=%b expected DEADBEEF/2/1/1", out_data, out_src, beat_cnt, out_valid); end
    sel = 2'd1; in_valid = 4'b0000;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL manual_ready_no_valid: got %b expected 0010", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== 32'hDEADBEEF || out_src !== 2'd2 || beat_cnt !== 16'd1) begin
      errors++; $display("FAIL manual_idle_hold: got v=%b data=%h src=%0d cnt=%0d expected 0/DEADBEEF/2/1", out_valid, out_data, out_src, beat_cnt); end
  endtask

  task automatic test_rr_fairness();
    do_reset();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < N; k++) ch[k] = $urandom;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (out_src !== 2'(i % N) || out_valid !== 1'b1 || out_data !== ch[i % N]) begin
        errors++; $display("FAIL rr_fair[%0d]: got src=%0d v=%b data=%h expected src=%0d v=1 data=%h", i, out_src, out_valid, out_data, i % N, ch[i % N]); end
    end
    checks++; if (beat_cnt !== 16'd8) begin errors++; $display("FAIL rr_fair_cnt: got %0d expected 8", beat_cnt); end
  endtask

  task automatic test_backpressure();
    logic [15:0] c0;
    logic [W-1:0] d0;
    in_valid = '0; out_ready = 1'b1;
    step();
    c0 = beat_cnt;
    d0 = ch[0];
    in_valid = 4'hF; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      for (int k = 0; k < N; k++) ch[k] = $urandom;
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== d0 || out_src !== 2'd0 || in_ready !== 4'h0 || beat_cnt !== c0 + 16'd1) begin
        errors++; $display("FAIL backpressure[%0d]: got v=%b data=%h src=%0d rdy=%b cnt=%0d expected 1/%h/0/0000/%0d", i, out_valid, out_data, out_src, in_ready, beat_cnt, d0, c0 + 16'd1); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b expected 0010", in_ready); end
    step();
    checks++; if (out_src !== 2'd1 || beat_cnt !== c0 + 16'd2) begin
      errors++; $display("FAIL bp_release: got src=%0d cnt=%0d expected 1/%0d", out_src, beat_cnt, c0 + 16'd2); end
  endtask

  task automatic test_sparse_rr();
    logic [3:0] pat [4];
    int         exp_g [4];
    pat[0] = 4'b0100; pat[1] = 4'b0010; pat[2] = 4'b1001; pat[3] = 4'b1001;
    exp_g[0] = 2; exp_g[1] = 1; exp_g[2] = 3; exp_g[3] = 0;
    do_reset();
    mode = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = pat[i];
      #1;
      checks++; if (in_ready !== 4'(1 << exp_g[i])) begin
        errors++; $display("FAIL sparse_ready[%0d]: got %b expected %b", i, in_ready, 4'(1 << exp_g[i])); end
      step();
      checks++; if (out_src !== 2'(exp_g[i]) || out_data !== ch[exp_g[i]]) begin
        errors++; $display("FAIL sparse_grant[%0d]: got src=%0d data=%h expected %0d/%h", i, out_src, out_data, exp_g[i], ch[exp_g[i]]); end
    end
  endtask

  task automatic test_n3();
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #1;
    checks++; if (in_ready3 !== 3'b000) begin errors++; $display("FAIL n3_sel_oob_ready: got %b expected 000", in_ready3); end
    step();
    checks++; if (out_valid3 !== 1'b0 || beat_cnt3 !== 16'd0) begin
      errors++; $display("FAIL n3_sel_oob_xfer: got v=%b cnt=%0d expected 0/0", out_valid3, beat_cnt3); end
    mode3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (out_src3 !== 2'(i % N3) || out_data3 !== ch3[i % N3]) begin
        errors++; $display("FAIL n3_rr_wrap[%0d]: got src=%0d data=%h expected %0d/%h", i, out_src3, out_data3, i % N3, ch3[i % N3]); end
    end
    checks++; if (beat_cnt3 !== 16'd5) begin errors++; $display("FAIL n3_cnt: got %0d expected 5", beat_cnt3); end
    in_valid3 = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) ch[k] = $urandom;
      #1;
      er = ref_ready();
      checks++; if (in_ready !== er) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, in_ready, er); end
      step();
      checks++; if (out_valid !== m_ov || out_data !== m_od || out_src !== 2'(m_src) || beat_cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL rand_out[%0d]: got v=%b data=%h src=%0d cnt=%0d expected %b/%h/%0d/%0d",
                           i, out_valid, out_data, out_src, beat_cnt, m_ov, m_od, m_src, m_cnt); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_rr_fairness();
    test_backpressure();
    test_sparse_rr();
    test_n3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
